// File: rtl/downcounter_tens.sv
// Two-digit BCD down counter with programmable wrap value, hold-at-zero mode,
// and registered borrow/done pulses for cascading countdown stages.
module downcounter_tens (
  input  logic       clk,
  input  logic       rst,
  input  logic       decrease,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic [7:0] wrap_val,
  input  logic       hold_at_zero,
  output logic [7:0] cnt,
  output logic       borrow,
  output logic       done,
  output logic       zero
);

  localparam logic [3:0] DIGIT_MAX  = 4'h9;
  localparam logic [3:0] DIGIT_ZERO = 4'h0;
  localparam logic [3:0] DIGIT_ONE  = 4'h1;
  localparam logic [7:0] BCD_ZERO   = 8'h00;

  // Out-of-range nibbles clamp to 9, each digit on its own.
  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > DIGIT_MAX) ? DIGIT_MAX : d;
  endfunction

  function automatic logic [7:0] sanitize(input logic [7:0] v);
    return {clamp_digit(v[7:4]), clamp_digit(v[3:0])};
  endfunction

  logic [3:0] tens_q, ones_q;
  logic [3:0] tens_d, ones_d;
  logic       borrow_d, done_d;
  logic [7:0] load_clean, wrap_clean;

  assign load_clean = sanitize(load_val);
  assign wrap_clean = sanitize(wrap_val);
  assign cnt        = {tens_q, ones_q};
  assign zero       = (cnt == BCD_ZERO);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    tens_d   = tens_q;
    ones_d   = ones_q;
    borrow_d = 1'b0;
    done_d   = 1'b0;
    if (load) begin
      tens_d = load_clean[7:4];
      ones_d = load_clean[3:0];
    end else if (decrease) begin
      if (ones_q != DIGIT_ZERO) begin
        ones_d = ones_q - DIGIT_ONE;
        done_d = (tens_q == DIGIT_ZERO) && (ones_q == DIGIT_ONE);
      end else if (tens_q != DIGIT_ZERO) begin
        ones_d = DIGIT_MAX;
        tens_d = tens_q - DIGIT_ONE;
      end else if (!hold_at_zero) begin
        // Wrapping out of 00 never raises done, even when wrap_val is 00.
        tens_d   = wrap_clean[7:4];
        ones_d   = wrap_clean[3:0];
        borrow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tens_q <= DIGIT_ZERO;
      ones_q <= DIGIT_ZERO;
      borrow <= 1'b0;
      done   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep all registers updating from the same pre-edge values.
      tens_q <= tens_d;
      ones_q <= ones_d;
      borrow <= borrow_d;
      done   <= done_d;
    end
  end

endmodule
